// File: rtl/hx8k_demo_pkg.sv
// Shared constants and state encodings for the HX8K flash-to-UART demo.
package hx8k_demo_pkg;

    localparam logic [7:0]  CMD_WAKE      = 8'hAB;
    localparam logic [7:0]  CMD_READ      = 8'h03;
    localparam int unsigned IDLE_WAIT_LEN = 16;
    localparam int unsigned GAP_LEN       = 8;
    localparam int unsigned WAIT_W        = 5;
    localparam int unsigned WAKE_BITS     = 8;
    localparam int unsigned CMD_BITS      = 32;
    localparam int unsigned BYTE_BITS     = 8;
    localparam int unsigned BIT_CNT_W     = 6;

    typedef enum logic [2:0] {
        IDLE_WAIT,
        WAKE,
        GAP,
        CMD,
        READ,
        SEND,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/hx8k_uart_tx.sv
// UART 8N1 transmitter: latches data on start, busy until the stop bit has fully elapsed.
module hx8k_uart_tx
    import hx8k_demo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 106
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_d;
    logic             busy_d;
    logic             bit_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx        <= tx_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx;
        busy_d    = busy;
        bit_end   = (cnt_q == CNT_LAST);

        if (state_q != TX_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    state_d = TX_START;
                    shreg_d = data;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d = TX_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/hx8k_demo.sv
// Wakes the SPI flash, streams NUM_BYTES from FLASH_ADDR and echoes each byte to LEDs and UART.
module hx8k_demo
    import hx8k_demo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 106,
    parameter logic [23:0] FLASH_ADDR   = 24'h100000,
    parameter int unsigned NUM_BYTES    = 16,
    parameter int unsigned SPI_HALF     = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] leds,
    input  logic       ser_rx,
    output logic       ser_tx,
    output logic       flash_csb,
    output logic       flash_clk,
    inout  wire        flash_io0,
    inout  wire        flash_io1,
    inout  wire        flash_io2,
    inout  wire        flash_io3
);

    localparam int unsigned HALF_W = $clog2(SPI_HALF + 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SPI_HALF - 1);

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [HALF_W-1:0]     half_cnt_q, half_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0]           sh_out_q, sh_out_d;
    logic [7:0]            sh_in_q, sh_in_d;
    logic [15:0]           byte_cnt_q, byte_cnt_d;
    logic [7:0]            leds_d;
    logic                  csb_d;
    logic                  sclk_d;
    logic                  phase_end;
    logic [BIT_CNT_W-1:0]  shift_len;
    logic                  tx_start_c;
    logic                  tx_busy;
    logic                  unused_rx;

    // MOSI is the MSB of the shift register; it is all-zero outside command phases.
    assign flash_io0 = sh_out_q[31];
    assign flash_io1 = 1'bz;
    assign flash_io2 = 1'b1;
    assign flash_io3 = 1'b1;
    assign unused_rx = ser_rx;

    hx8k_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .data  (sh_in_q),
        .start (tx_start_c),
        .busy  (tx_busy),
        .tx    (ser_tx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE_WAIT;
            wait_cnt_q <= '0;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sh_out_q   <= '0;
            sh_in_q    <= '0;
            byte_cnt_q <= '0;
            leds       <= '0;
            flash_csb  <= 1'b1;
            flash_clk  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_out_q   <= sh_out_d;
            sh_in_q    <= sh_in_d;
            byte_cnt_q <= byte_cnt_d;
            leds       <= leds_d;
            flash_csb  <= csb_d;
            flash_clk  <= sclk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sh_out_d   = sh_out_q;
        sh_in_d    = sh_in_q;
        byte_cnt_d = byte_cnt_q;
        leds_d     = leds;
        csb_d      = flash_csb;
        sclk_d     = flash_clk;
        tx_start_c = 1'b0;
        phase_end  = (half_cnt_q == HALF_LAST);
        shift_len  = (state_q == WAKE) ? BIT_CNT_W'(WAKE_BITS) : BIT_CNT_W'(CMD_BITS);

        case (state_q)
            IDLE_WAIT: begin
                if (wait_cnt_q == WAIT_W'(IDLE_WAIT_LEN - 1)) begin
                    state_d    = WAKE;
                    csb_d      = 1'b0;
                    sh_out_d   = {CMD_WAKE, 24'h000000};
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            // Shared bit engine: low phase then high phase per bit, one trailing low phase before exit.
            WAKE, CMD, READ: begin
                half_cnt_d = phase_end ? '0 : half_cnt_q + HALF_W'(1);
                if (phase_end) begin
                    if (!flash_clk) begin
                        if (state_q != READ && bit_cnt_q == shift_len) begin
                            if (state_q == WAKE) begin
                                state_d    = GAP;
                                csb_d      = 1'b1;
                                wait_cnt_d = '0;
                            end else begin
                                state_d   = READ;
                                bit_cnt_d = '0;
                            end
                        end else begin
                            sclk_d  = 1'b1;
                            sh_in_d = {sh_in_q[6:0], flash_io1};
                        end
                    end else begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        sh_out_d  = {sh_out_q[30:0], 1'b0};
                        if (state_q == READ && bit_cnt_q == BIT_CNT_W'(BYTE_BITS - 1)) begin
                            state_d    = SEND;
                            bit_cnt_d  = '0;
                            leds_d     = sh_in_q;
                            byte_cnt_d = byte_cnt_q + 16'd1;
                            tx_start_c = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (wait_cnt_q == WAIT_W'(GAP_LEN - 1)) begin
                    state_d    = CMD;
                    csb_d      = 1'b0;
                    sh_out_d   = {CMD_READ, FLASH_ADDR};
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            // Flash stays selected so the next READ continues the sequential stream.
            SEND: begin
                if (!tx_busy) begin
                    if (byte_cnt_q == 16'(NUM_BYTES)) begin
                        state_d = DONE;
                        csb_d   = 1'b1;
                    end else begin
                        state_d    = READ;
                        half_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
            end
            DONE: begin
                csb_d  = 1'b1;
                sclk_d = 1'b0;
            end
            default: state_d = IDLE_WAIT;
        endcase
    end

endmodule

// File: tb/tb_hx8k_demo.sv
// Directed bench for hx8k_demo with a behavioural SPI flash and a UART frame sampler.
module tb_hx8k_demo;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       ser_rx = 1'b1;
    logic [7:0] leds;
    logic       ser_tx;
    logic       flash_csb;
    logic       flash_clk;
    wire        flash_io0;
    wire        flash_io1;
    wire        flash_io2;
    wire        flash_io3;

    int    n_cmp   = 0;
    int    n_bad   = 0;
    longint cyc    = 0;
    int    io_viol = 0;

    // Flash model state
    logic [7:0]  mem [0:31];
    int          bitc     = 0;
    logic [31:0] shin     = '0;
    int          n_win    = 0;
    int          win_bits = 0;
    logic [31:0] win_word = '0;
    logic [31:0] cmd_word = '0;
    logic        cmd_seen = 1'b0;
    logic        miso     = 1'b0;
    int          rd_idx;
    logic [23:0] rd_off;

    hx8k_demo #(
        .CLKS_PER_BIT(106),
        .FLASH_ADDR  (24'h100000),
        .NUM_BYTES   (16),
        .SPI_HALF    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .leds      (leds),
        .ser_rx    (ser_rx),
        .ser_tx    (ser_tx),
        .flash_csb (flash_csb),
        .flash_clk (flash_clk),
        .flash_io0 (flash_io0),
        .flash_io1 (flash_io1),
        .flash_io2 (flash_io2),
        .flash_io3 (flash_io3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (flash_io2 !== 1'b1 || flash_io3 !== 1'b1) io_viol <= io_viol + 1;

    assign flash_io1 = flash_csb ? 1'bz : miso;

    // Flash: capture MOSI on rising edges, record each completed chip-select window.
    always @(posedge flash_clk or posedge flash_csb) begin
        if (flash_csb) begin
            if (bitc > 0) begin
                n_win    <= n_win + 1;
                win_bits <= bitc;
                win_word <= shin;
            end
            bitc <= 0;
            shin <= '0;
        end else begin
            if (bitc < 32) shin <= {shin[30:0], flash_io0};
            if (bitc == 31) begin
                cmd_word <= {shin[30:0], flash_io0};
                cmd_seen <= 1'b1;
            end
            bitc <= bitc + 1;
        end
    end

    // Flash: after a 0x03 command, present data MSB first on falling edges.
    always @(negedge flash_clk) begin
        if (!flash_csb && bitc >= 32 && shin[31:24] == 8'h03) begin
            rd_idx = bitc - 32;
            rd_off = shin[23:0] - 24'h100000 + 24'(rd_idx / 8);
            miso  <= mem[rd_off[4:0]][3'(7 - (rd_idx % 8))];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_start(output logic found, output longint at);
        found = 1'b0;
        at    = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (ser_tx === 1'b0) begin
                found = 1'b1;
                at    = cyc;
                break;
            end
        end
    endtask

    // Sample mid-bit: 53 cycles after the start edge, then every 106 cycles.
    task automatic rx_frame(output logic [9:0] bits);
        tick(53);
        bits[0] = ser_tx;
        for (int k = 1; k < 10; k++) begin
            tick(106);
            bits[k] = ser_tx;
        end
    endtask

    initial begin
        logic       found;
        longint     t_prev;
        longint     t_now;
        logic [9:0] fb;
        int         n;
        int         frames;
        int         wn;
        logic       act;
        string      s;

        s = "Hi\nhx8k demo ok!";
        for (int i = 0; i < 32; i++) mem[i] = (i < 16) ? s[i] : 8'h00;
        frames = 0;
        t_prev = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_leds", 32'(leds), 32'h00);
        chk("rst_ser_tx", 32'(ser_tx), 32'h1);
        chk("rst_csb", 32'(flash_csb), 32'h1);
        chk("rst_flash_clk", 32'(flash_clk), 32'h0);
        chk("rst_io0", 32'(flash_io0), 32'h0);
        chk("rst_io2", 32'(flash_io2), 32'h1);
        chk("rst_io3", 32'(flash_io3), 32'h1);

        @(negedge clk) reset = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (flash_csb === 1'b0) break;
        end
        chk("idle_wait_cycles", 32'(n), 32'd16);

        // Wake window, then measure the deselect gap
        for (int i = 0; i < 200 && flash_csb !== 1'b1; i++) tick(1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            n++;
            if (flash_csb === 1'b0) break;
        end
        chk("gap_ge_8", 32'(n >= 8), 32'h1);
        chk("wake_windows", 32'(n_win), 32'd1);
        chk("wake_clocks", 32'(win_bits), 32'd8);
        chk("wake_word", win_word, 32'h0000_00AB);

        for (int i = 0; i < 400 && !cmd_seen; i++) tick(1);
        chk("cmd_addr_word", cmd_word, 32'h0310_0000);

        // Sixteen UART frames carrying the flash contents
        for (int f = 0; f < 16; f++) begin
            wait_tx_start(found, t_now);
            chk($sformatf("frame%0d_start_seen", f), 32'(found), 32'h1);
            if (!found) break;
            chk($sformatf("frame%0d_leds", f), 32'(leds), 32'(mem[f]));
            if (f > 0) chk($sformatf("frame%0d_spacing", f), 32'((t_now - t_prev) >= 1060), 32'h1);
            t_prev = t_now;
            rx_frame(fb);
            chk($sformatf("frame%0d_data", f), 32'(fb[8:1]), 32'(mem[f]));
            chk($sformatf("frame%0d_start_stop", f), 32'({fb[9], fb[0]}), 32'h2);
            if (f == 2) chk("frame_0a_bits", 32'(fb), 32'(10'b10_0001_0100));
            frames++;
        end
        chk("frame_count", 32'(frames), 32'd16);

        tick(200);
        act = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (ser_tx !== 1'b1 || flash_csb !== 1'b1) act = 1'b1;
        end
        chk("done_quiet", 32'(act), 32'h0);
        chk("done_csb", 32'(flash_csb), 32'h1);
        chk("done_flash_clk", 32'(flash_clk), 32'h0);
        chk("done_ser_tx", 32'(ser_tx), 32'h1);
        chk("done_leds", 32'(leds), 32'h21);

        // Restart, then reset in the middle of data bit 3 of the first frame
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        wait_tx_start(found, t_now);
        chk("rerun_start_seen", 32'(found), 32'h1);
        tick(474);
        chk("midframe_csb_low", 32'(flash_csb), 32'h0);
        chk("midframe_leds", 32'(leds), 32'h48);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ser_tx", 32'(ser_tx), 32'h1);
        chk("async_rst_csb", 32'(flash_csb), 32'h1);
        chk("async_rst_leds", 32'(leds), 32'h00);
        chk("async_rst_flash_clk", 32'(flash_clk), 32'h0);
        chk("async_rst_io0", 32'(flash_io0), 32'h0);
        tick(3);
        @(negedge clk) reset = 1'b0;
        wn = n_win;
        for (int i = 0; i < 300 && n_win == wn; i++) tick(1);
        chk("rewake_windows", 32'(n_win), 32'(wn + 1));
        chk("rewake_clocks", 32'(win_bits), 32'd8);
        chk("rewake_word", win_word, 32'h0000_00AB);

        chk("io2_io3_constant", 32'(io_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hx8k_demo.md
HX8K_DEMO -- requirements
Module: hx8k_demo

Interface
REQ-001 Parameter CLKS_PER_BIT, 106, UART bit period in clk cycles (100 MHz clk, ~943 kBd).
REQ-002 Parameter FLASH_ADDR, 24'h100000, first flash byte address read.
REQ-003 Parameter NUM_BYTES, 16, bytes streamed per run (1..65535).
REQ-004 Parameter SPI_HALF, 2, clk cycles per flash_clk half-period (>=1).
REQ-005 Port clk input 1, single system clock, all logic on rising edge.
REQ-006 Port reset input 1, asynchronous active-high reset.
REQ-007 Port leds output 8, last byte read from flash.
REQ-008 Port ser_rx input 1, reserved, ignored.
REQ-009 Port ser_tx output 1, UART 8N1 transmit, idle high.
REQ-010 Port flash_csb output 1, SPI chip select, active low.
REQ-011 Port flash_clk output 1, SPI clock, mode 0, idle low.
REQ-012 Port flash_io0 inout 1, always driven, MOSI.
REQ-013 Port flash_io1 inout 1, never driven (high-Z), MISO.
REQ-014 Ports flash_io2/flash_io3 inout 1 each, always driven 1 (WP#/HOLD# inactive).

Function
REQ-015 Flash access SHALL be single-bit SPI, MSB first, io0 changed while flash_clk low, io1 sampled on flash_clk rising edge.
REQ-016 Each flash_clk phase SHALL last SPI_HALF clk cycles; flash_clk SHALL be low whenever flash_csb changes.
REQ-017 States: IDLE_WAIT -> WAKE -> GAP -> CMD -> READ -> SEND -> DONE.
REQ-018 IDLE_WAIT: 16 clk cycles after reset release, csb=1.
REQ-019 WAKE: csb low, shift 8'hAB (release power-down), csb high.
REQ-020 GAP: csb held high >= 8 clk cycles.
REQ-021 CMD: csb low, shift 8'h03 then FLASH_ADDR[23:0], csb stays low.
REQ-022 READ: 8 flash_clk pulses assemble one byte; on completion leds <= byte same cycle as UART start, go SEND.
REQ-023 SEND: flash_clk held low, csb held low until UART stop bit done; then READ if fewer than NUM_BYTES sent, else DONE.
REQ-024 DONE: csb high, flash_clk low, ser_tx high, leds hold last byte; remain until reset.
REQ-025 UART frame: start 0, 8 data bits LSB first, one stop 1, each exactly CLKS_PER_BIT cycles; no gap required between frames.
REQ-026 Byte counter 16-bit, compare against NUM_BYTES, no wrap; address auto-increments inside flash (sequential read).

Reset
REQ-027 Reset asserted (any time, including mid-frame/mid-transfer) SHALL immediately force leds=0, ser_tx=1, flash_csb=1, flash_clk=0, flash_io0=0, state IDLE_WAIT, counters 0.
REQ-028 After reset release the full sequence from REQ-018 SHALL restart, including WAKE.

Structure
REQ-029 Package hx8k_demo_pkg SHALL hold the state enum, CMD_WAKE=8'hAB, CMD_READ=8'h03, IDLE_WAIT length 16, GAP length 8.
REQ-030 UART transmitter SHALL be sub-module hx8k_uart_tx (clk, reset, data, start, busy, tx); SPI shifter and sequencer in top.

Verification
REQ-031 Reset release, spiflash model attached -> first csb-low window carries exactly 8 clocks with MOSI 0xAB; second carries 0x03,0x10,0x00,0x00.
REQ-032 Flash bytes at 0x100000 = 0x48,0x69,... -> ser_tx sampled at 53+106k cycles after start edge decodes 'H','i',...; leds show 8'h48 then 8'h69.
REQ-033 NUM_BYTES=16 -> exactly 16 UART frames, then csb=1 permanently, leds = byte at 0x10000F, ser_tx=1.
REQ-034 Assert reset mid-frame (during data bit 3) -> same cycle ser_tx=1, csb=1, leds=0; after release 0xAB resent.
REQ-035 Flash byte 0x0A -> frame bits 0,0,1,0,1,0,0,0,0,1 each 106 cycles; frame-to-frame start edges >= 1060 cycles apart.
REQ-036 flash_io1 never driven by DUT, flash_io2/io3 constant 1 throughout all scenarios.
